// File: rtl/aemb2_xslarb_if.sv
`default_nettype none
// ============================================================================
//  Module   : aemb2_xslarb_if
//  Purpose  : XSL Wishbone point-to-point bus bundle. One instance per bus
//             segment: each requesting master has its own instance, and so
//             does the shared accelerator slave.
//  Signals  : adr  [AEMB_XWB-1:2]  word address        (master -> slave)
//             wdat [31:0]          write data          (master -> slave)
//             tag, wre             control / write en  (master -> slave)
//             sel  [3:0]           byte lane select    (master -> slave)
//             stb, cyc             request qualifiers  (master -> slave)
//             rdat [31:0]          read data           (slave -> master)
//             ack                  acknowledge         (slave -> master)
//  Modports : master (drives the request side), slave (answers it)
//  Revision : 1.0  initial release
// ============================================================================
interface aemb2_xslarb_if #(
    parameter int AEMB_XWB = 3
);
    logic [AEMB_XWB-1:2] adr;
    logic [31:0]         wdat;
    logic                tag;
    logic                wre;
    logic [3:0]          sel;
    logic                stb;
    logic                cyc;
    logic [31:0]         rdat;
    logic                ack;

    modport master (
        output adr, wdat, tag, wre, sel, stb, cyc,
        input  rdat, ack
    );

    // The arbiter never looks at master byte selects (the slave always gets
    // full-word lanes), so sel is left out of the answering side.
    modport slave (
        input  adr, wdat, tag, wre, stb, cyc,
        output rdat, ack
    );
endinterface
`default_nettype wire

// File: rtl/aemb2_xslarb.sv
`default_nettype none
// ============================================================================
//  Module   : aemb2_xslarb
//  Purpose  : Two-master round-robin arbiter for the XSL accelerator bus.
//             A grant is held until the slave acks, the owner withdraws its
//             strobe, or a watchdog expires; on expiry the owner receives a
//             dummy ack with zero data so its pipeline cannot stall forever.
//  Ports    : gclk   in   system clock, rising edge
//             grst   in   asynchronous active-low reset
//             m0     slave modport   requesting master 0
//             m1     slave modport   requesting master 1
//             xwb    master modport  shared accelerator slave (all request
//                                    outputs registered)
//             gnt_o  out  one-hot current owner, 2'b00 when idle
//             tmo_o  out  one-cycle pulse on a watchdog termination
//  Revision : 1.0  initial release
// ============================================================================
module aemb2_xslarb #(
    parameter int AEMB_XWB = 3,
    parameter int AEMB_TMO = 8
) (
    input  logic                  gclk,
    input  logic                  grst,
    aemb2_xslarb_if.slave         m0,
    aemb2_xslarb_if.slave         m1,
    aemb2_xslarb_if.master        xwb,
    output logic [1:0]            gnt_o,
    output logic                  tmo_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [AEMB_TMO-1:0] CNT_MAX = '1;

    state_t              state_q, state_d;
    logic                last_q,  last_d;   // 0 = m0, 1 = m1; also the owner while BUSY
    logic [AEMB_TMO-1:0] cnt_q,   cnt_d;
    logic [1:0]          gnt_q,   gnt_d;
    logic                stb_q,   stb_d;
    logic [AEMB_XWB-1:2] adr_q,   adr_d;
    logic [31:0]         dat_q,   dat_d;
    logic                tag_q,   tag_d;
    logic                wre_q,   wre_d;

    logic w_req0, w_req1;
    logic w_pick;       // master chosen in IDLE
    logic w_own_stb;    // owner's live strobe
    logic w_ack_own;    // ack (real or dummy) destined for the owner
    logic w_tmo;        // watchdog termination this cycle

    assign w_req0 = m0.stb & m0.cyc;
    assign w_req1 = m1.stb & m1.cyc;

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;    // m0 wins the first tie
            cnt_q   <= '0;
            gnt_q   <= 2'b00;
            stb_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            tag_q   <= 1'b0;
            wre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            tag_q   <= tag_d;
            wre_q   <= wre_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        stb_d     = stb_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        tag_d     = tag_q;
        wre_d     = wre_q;
        w_pick    = 1'b0;
        w_own_stb = last_q ? m1.stb : m0.stb;
        w_ack_own = 1'b0;
        w_tmo     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_req0 | w_req1) begin
                    // On a tie the master that did not go last is served.
                    w_pick  = (w_req0 & w_req1) ? ~last_q : w_req1;
                    adr_d   = w_pick ? m1.adr  : m0.adr;
                    dat_d   = w_pick ? m1.wdat : m0.wdat;
                    tag_d   = w_pick ? m1.tag  : m0.tag;
                    wre_d   = w_pick ? m1.wre  : m0.wre;
                    gnt_d   = w_pick ? 2'b10   : 2'b01;
                    last_d  = w_pick;
                    cnt_d   = '0;
                    stb_d   = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (xwb.ack) begin
                    // A real ack beats a simultaneous watchdog expiry.
                    w_ack_own = 1'b1;
                    stb_d     = 1'b0;
                    gnt_d     = 2'b00;
                    state_d   = S_IDLE;
                end else if (!w_own_stb) begin
                    // Owner abandoned the cycle: drop it silently.
                    stb_d     = 1'b0;
                    gnt_d     = 2'b00;
                    state_d   = S_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    w_ack_own = 1'b1;
                    w_tmo     = 1'b1;
                    stb_d     = 1'b0;
                    gnt_d     = 2'b00;
                    state_d   = S_IDLE;
                end else begin
                    // cnt_q is below its maximum here, so this never wraps.
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign m0.ack  = w_ack_own & ~last_q;
    assign m1.ack  = w_ack_own &  last_q;
    // Read data is broadcast; only the timed-out owner sees forced zeros.
    assign m0.rdat = (w_tmo & ~last_q) ? 32'h0 : xwb.rdat;
    assign m1.rdat = (w_tmo &  last_q) ? 32'h0 : xwb.rdat;

    assign xwb.adr  = adr_q;
    assign xwb.wdat = dat_q;
    assign xwb.tag  = tag_q;
    assign xwb.wre  = wre_q;
    assign xwb.sel  = 4'hF;
    assign xwb.stb  = stb_q;
    assign xwb.cyc  = stb_q;

    assign gnt_o = gnt_q;
    assign tmo_o = w_tmo;

endmodule
`default_nettype wire

// File: tb/tb_aemb2_xslarb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aemb2_xslarb
//  Purpose  : Directed self-checking bench for aemb2_xslarb (AEMB_TMO = 3,
//             so the watchdog terminates in the 8th BUSY cycle, cnt == 7).
//  Revision : 1.0  initial release
// ============================================================================
module tb_aemb2_xslarb;

    localparam int XWB = 6;
    localparam int TMO = 3;

    logic       gclk = 1'b0;
    logic       grst;
    logic [1:0] gnt;
    logic       tmo;
    int         total = 0;
    int         bad   = 0;

    aemb2_xslarb_if #(.AEMB_XWB(XWB)) m0_bus (), m1_bus (), xwb_bus ();

    aemb2_xslarb #(
        .AEMB_XWB (XWB),
        .AEMB_TMO (TMO)
    ) dut (
        .gclk  (gclk),
        .grst  (grst),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .xwb   (xwb_bus),
        .gnt_o (gnt),
        .tmo_o (tmo)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic req0(input logic on, input logic [3:0] a, input logic [31:0] d, input logic t, input logic w);
        m0_bus.stb = on; m0_bus.cyc = on; m0_bus.adr = a; m0_bus.wdat = d; m0_bus.tag = t; m0_bus.wre = w;
    endtask

    task automatic req1(input logic on, input logic [3:0] a, input logic [31:0] d, input logic t, input logic w);
        m1_bus.stb = on; m1_bus.cyc = on; m1_bus.adr = a; m1_bus.wdat = d; m1_bus.tag = t; m1_bus.wre = w;
    endtask

    logic [1:0] fair_gnt [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    initial begin
        grst = 1'b0;
        m0_bus.sel = 4'hF; m1_bus.sel = 4'hF;
        req0(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        req1(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        xwb_bus.ack = 1'b0; xwb_bus.rdat = 32'h0;
        tick(); tick();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_stb", xwb_bus.stb, 1'b0);
        chk("rst_cyc", xwb_bus.cyc, 1'b0);
        chk("rst_adr", xwb_bus.adr, 4'h0);
        chk("rst_tmo", tmo, 1'b0);
        grst = 1'b1;
        tick();

        // ---- single master write, slave acks two cycles after stb ----
        req0(1'b1, 4'h1, 32'hDEADBEEF, 1'b0, 1'b1);
        tick();
        chk("t1_stb", xwb_bus.stb, 1'b1);
        chk("t1_cyc", xwb_bus.cyc, 1'b1);
        chk("t1_sel", xwb_bus.sel, 4'hF);
        chk("t1_adr", xwb_bus.adr, 4'h1);
        chk("t1_dat", xwb_bus.wdat, 32'hDEADBEEF);
        chk("t1_wre", xwb_bus.wre, 1'b1);
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_ack0_wait", m0_bus.ack, 1'b0);
        tick();
        tick();
        xwb_bus.ack = 1'b1; xwb_bus.rdat = 32'hCAFEF00D;
        #1;
        chk("t1_ack0", m0_bus.ack, 1'b1);
        chk("t1_rdat0", m0_bus.rdat, 32'hCAFEF00D);
        chk("t1_ack1", m1_bus.ack, 1'b0);
        chk("t1_tmo", tmo, 1'b0);
        tick();
        xwb_bus.ack = 1'b0; m0_bus.stb = 1'b0; m0_bus.cyc = 1'b0;
        #1;
        chk("t1_stb_drop", xwb_bus.stb, 1'b0);
        chk("t1_gnt_idle", gnt, 2'b00);
        chk("t1_adr_hold", xwb_bus.adr, 4'h1);
        chk("t1_ack0_done", m0_bus.ack, 1'b0);

        // ---- fairness from a fresh reset, zero-wait slave ----
        grst = 1'b0; #1; grst = 1'b1;
        req0(1'b1, 4'h2, 32'h00000002, 1'b0, 1'b0);
        req1(1'b1, 4'h3, 32'h00000003, 1'b0, 1'b0);
        xwb_bus.ack = 1'b1; xwb_bus.rdat = 32'h0BADF00D;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("fair_gnt%0d", i), gnt, fair_gnt[i]);
            chk($sformatf("fair_ack0_%0d", i), m0_bus.ack, fair_gnt[i][0]);
            chk($sformatf("fair_ack1_%0d", i), m1_bus.ack, fair_gnt[i][1]);
            if (fair_gnt[i] != 2'b00)
                chk($sformatf("fair_adr%0d", i), xwb_bus.adr, fair_gnt[i][1] ? 4'h3 : 4'h2);
        end
        req0(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        req1(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        xwb_bus.ack = 1'b0;
        tick();

        // ---- watchdog timeout on m1, silent slave ----
        req1(1'b1, 4'h5, 32'h00000055, 1'b1, 1'b0);
        xwb_bus.rdat = 32'hAAAA5555;
        tick();
        chk("to_gnt", gnt, 2'b10);
        chk("to_tag", xwb_bus.tag, 1'b1);
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("to_wait_tmo%0d", k), tmo, 1'b0);
            chk($sformatf("to_wait_ack%0d", k), m1_bus.ack, 1'b0);
            tick();
        end
        chk("to_tmo", tmo, 1'b1);
        chk("to_ack1", m1_bus.ack, 1'b1);
        chk("to_rdat1", m1_bus.rdat, 32'h0);
        chk("to_ack0", m0_bus.ack, 1'b0);
        chk("to_rdat0_bcast", m0_bus.rdat, 32'hAAAA5555);
        tick();
        m1_bus.stb = 1'b0; m1_bus.cyc = 1'b0;
        #1;
        chk("to_idle_stb", xwb_bus.stb, 1'b0);
        chk("to_idle_gnt", gnt, 2'b00);
        chk("to_idle_tmo", tmo, 1'b0);

        // ---- ack coincides with timeout on m0 ----
        req0(1'b1, 4'h6, 32'h00000066, 1'b0, 1'b0);
        tick();
        chk("co_gnt", gnt, 2'b01);
        for (int k = 1; k < 8; k++) tick();
        xwb_bus.ack = 1'b1; xwb_bus.rdat = 32'h12345678;
        #1;
        chk("co_ack0", m0_bus.ack, 1'b1);
        chk("co_rdat0", m0_bus.rdat, 32'h12345678);
        chk("co_tmo", tmo, 1'b0);
        tick();
        xwb_bus.ack = 1'b0; m0_bus.stb = 1'b0; m0_bus.cyc = 1'b0;
        #1;
        chk("co_idle_stb", xwb_bus.stb, 1'b0);

        // ---- abort by m0 while m1 waits ----
        req0(1'b1, 4'h7, 32'h00000077, 1'b0, 1'b1);
        tick();
        chk("ab_gnt0", gnt, 2'b01);
        req1(1'b1, 4'h9, 32'h00000099, 1'b0, 1'b1);
        tick();
        chk("ab_hold_gnt", gnt, 2'b01);
        tick();
        m0_bus.stb = 1'b0;
        #1;
        chk("ab_ack0", m0_bus.ack, 1'b0);
        chk("ab_ack1", m1_bus.ack, 1'b0);
        tick();
        m0_bus.cyc = 1'b0;
        chk("ab_stb_drop", xwb_bus.stb, 1'b0);
        chk("ab_gnt_idle", gnt, 2'b00);
        chk("ab_ack0_idle", m0_bus.ack, 1'b0);
        tick();
        chk("ab_gnt1", gnt, 2'b10);
        chk("ab_adr1", xwb_bus.adr, 4'h9);
        chk("ab_stb1", xwb_bus.stb, 1'b1);
        xwb_bus.ack = 1'b1; xwb_bus.rdat = 32'h00C0FFEE;
        #1;
        chk("ab_ack1_done", m1_bus.ack, 1'b1);
        chk("ab_ack0_done", m0_bus.ack, 1'b0);
        tick();
        xwb_bus.ack = 1'b0;
        req1(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        tick();

        // ---- reset asserted mid-transfer ----
        req0(1'b1, 4'h4, 32'h44444444, 1'b1, 1'b1);
        tick();
        chk("rm_gnt_busy", gnt, 2'b01);
        req1(1'b1, 4'hA, 32'hAAAAAAAA, 1'b0, 1'b0);
        #1;
        grst = 1'b0;
        #1;
        chk("rm_gnt", gnt, 2'b00);
        chk("rm_stb", xwb_bus.stb, 1'b0);
        chk("rm_adr", xwb_bus.adr, 4'h0);
        chk("rm_dat", xwb_bus.wdat, 32'h0);
        chk("rm_tag", xwb_bus.tag, 1'b0);
        chk("rm_wre", xwb_bus.wre, 1'b0);
        xwb_bus.ack = 1'b1;
        #1;
        chk("rm_ack0", m0_bus.ack, 1'b0);
        chk("rm_ack1", m1_bus.ack, 1'b0);
        chk("rm_tmo", tmo, 1'b0);
        xwb_bus.ack = 1'b0;
        #1;
        grst = 1'b1;
        tick();
        chk("rm_regrant", gnt, 2'b01);
        chk("rm_regrant_adr", xwb_bus.adr, 4'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
